alu_dword_seq: RTL

- Multi-cycle sequencer that runs 64-bit add/subtract/compare operations through the existing 32-bit combinational ALU.
- Low words are processed first, then high words, with the carry chained through the ALU c_in input.
- Holds the architectural NZCV flag register for these operations.
- Sits beside the ALU in the execute stage and owns the ALU operand and opcode inputs whenever it is busy.

---
 rtl/alu_dword_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_dword_seq.sv
// alu_dword_seq: sequences 64-bit ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN through a
//   32-bit combinational ALU (low word first, then high word with chained carry)
//   and holds the architectural NZCV flag register for those operations.
// Latency: start accepted at edge T, done pulses during cycle T+2..T+3; start is
//   accepted again from DONE, giving a 3-cycle issue interval.
// Backpressure: none; start is only taken in IDLE/DONE and is dropped (not queued)
//   while busy.
// Optional feature macro: ALU_SEQ_ABORT_EN adds input 'abort', which cancels an
//   operation in LO/HI with no result, flag update or done pulse.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, op, set_flags             request, opcode, flag-update enable
//   a_lo, a_hi, b_lo, b_hi           64-bit operands, sampled on acceptance
//   alu_src1, alu_src2, alu_op,
//   alu_cin                          registered drive into the external ALU
//   alu_out, alu_nzcv                ALU result and {N,Z,C,V}
//   busy, done, result_we            status; result_we = done for ops 000-101
//   result_lo, result_hi, nzcv       result registers and flag register
module alu_dword_seq #(
  parameter logic [3:0] NZCV_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        set_flags,
  input  logic [31:0] a_lo,
  input  logic [31:0] a_hi,
  input  logic [31:0] b_lo,
  input  logic [31:0] b_hi,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic [3:0]  alu_nzcv,
  output logic        busy,
  output logic        done,
  output logic        result_we,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [3:0]  nzcv
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] ALU_MOV = 4'b1101;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        sf_q, sf_d;
  logic [31:0] a_hi_q, a_hi_d;
  logic [31:0] b_hi_q, b_hi_d;
  logic [31:0] lo_res_q, lo_res_d;
  logic        z_lo_q, z_lo_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [3:0]  aluop_q, aluop_d;
  logic        cin_q, cin_d;

  logic        abort_w;
  logic [3:0]  lo_opc;
  logic        lo_use_c;
  logic [3:0]  hi_opc;
  logic        is_cmp_q;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // CMP (110) and CMN (111) share op[2:1]=11: flags only, no result write.
  assign is_cmp_q = (op_q[2:1] == 2'b11);

  // Low-word opcode for the incoming request; the carry-using variants
  // (ADC/SBC/RSC) take the architectural C flag as carry-in.
  always_comb begin
    lo_opc   = 4'b0100;
    lo_use_c = 1'b0;
    case (op)
      3'b000: lo_opc = 4'b0100;
      3'b001: begin lo_opc = 4'b0101; lo_use_c = 1'b1; end
      3'b010: lo_opc = 4'b0010;
      3'b011: begin lo_opc = 4'b0110; lo_use_c = 1'b1; end
      3'b100: lo_opc = 4'b0011;
      3'b101: begin lo_opc = 4'b0111; lo_use_c = 1'b1; end
      3'b110: lo_opc = 4'b0010;
      3'b111: lo_opc = 4'b0100;
      default: lo_opc = 4'b0100;
    endcase
  end

  // High word always uses the carry-chaining form of its family.
  always_comb begin
    hi_opc = 4'b0101;
    case (op_q)
      3'b010, 3'b011, 3'b110: hi_opc = 4'b0110;
      3'b100, 3'b101:         hi_opc = 4'b0111;
      default:                hi_opc = 4'b0101;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sf_d     = sf_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    lo_res_d = lo_res_q;
    z_lo_d   = z_lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    nzcv_d   = nzcv_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    aluop_d  = aluop_q;
    cin_d    = cin_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LO;
          op_d    = op;
          sf_d    = set_flags | (op[2:1] == 2'b11);
          a_hi_d  = a_hi;
          b_hi_d  = b_hi;
          src1_d  = a_lo;
          src2_d  = b_lo;
          aluop_d = lo_opc;
          cin_d   = lo_use_c ? nzcv_q[1] : 1'b0;
        end else begin
          state_d = S_IDLE;
          src1_d  = '0;
          src2_d  = '0;
          aluop_d = ALU_MOV;
          cin_d   = 1'b0;
        end
      end
      S_LO: begin
        if (abort_w) begin
          state_d = S_IDLE;
          src1_d  = '0;
          src2_d  = '0;
          aluop_d = ALU_MOV;
          cin_d   = 1'b0;
        end else begin
          state_d  = S_HI;
          lo_res_d = alu_out;
          z_lo_d   = alu_nzcv[2];
          src1_d   = a_hi_q;
          src2_d   = b_hi_q;
          aluop_d  = hi_opc;
          cin_d    = alu_nzcv[1];
        end
      end
      S_HI: begin
        state_d = abort_w ? S_IDLE : S_DONE;
        src1_d  = '0;
        src2_d  = '0;
        aluop_d = ALU_MOV;
        cin_d   = 1'b0;
        if (!abort_w) begin
          if (!is_cmp_q) begin
            res_lo_d = lo_res_q;
            res_hi_d = alu_out;
          end
          // 64-bit zero needs both halves zero; the rest come from the high word.
          if (sf_q) begin
            nzcv_d = {alu_nzcv[3], z_lo_q & alu_nzcv[2], alu_nzcv[1], alu_nzcv[0]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      sf_q     <= 1'b0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      lo_res_q <= '0;
      z_lo_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      nzcv_q   <= NZCV_RESET;
      src1_q   <= '0;
      src2_q   <= '0;
      aluop_q  <= ALU_MOV;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sf_q     <= sf_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      lo_res_q <= lo_res_d;
      z_lo_q   <= z_lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      nzcv_q   <= nzcv_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      aluop_q  <= aluop_d;
      cin_q    <= cin_d;
    end
  end

  assign alu_src1  = src1_q;
  assign alu_src2  = src2_q;
  assign alu_op    = aluop_q;
  assign alu_cin   = cin_q;
  assign busy      = (state_q == S_LO) || (state_q == S_HI);
  assign done      = (state_q == S_DONE);
  assign result_we = done && !is_cmp_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign nzcv      = nzcv_q;

endmodule
